// File: rtl/cga_dac_pkg.sv
// Shared definitions for the CGA colour DAC: register map, sequencer phases
// and the power-up palette (standard CGA 16 colours, 6 bits per component).
package cga_dac_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int COMP_W      = 6;
  localparam int IDX_W       = 4;
  localparam int ENTRY_W     = 3 * COMP_W;

  localparam logic [1:0] ADDR_WIDX = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_RIDX = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // Entries are packed {red, green, blue}.
  localparam logic [ENTRY_W-1:0] DEFAULT_PALETTE [NUM_ENTRIES] = '{
    {6'h00, 6'h00, 6'h00},
    {6'h00, 6'h00, 6'h2A},
    {6'h00, 6'h2A, 6'h00},
    {6'h00, 6'h2A, 6'h2A},
    {6'h2A, 6'h00, 6'h00},
    {6'h2A, 6'h00, 6'h2A},
    {6'h2A, 6'h15, 6'h00},
    {6'h2A, 6'h2A, 6'h2A},
    {6'h15, 6'h15, 6'h15},
    {6'h15, 6'h15, 6'h3F},
    {6'h15, 6'h3F, 6'h15},
    {6'h15, 6'h3F, 6'h3F},
    {6'h3F, 6'h15, 6'h15},
    {6'h3F, 6'h15, 6'h3F},
    {6'h3F, 6'h3F, 6'h15},
    {6'h3F, 6'h3F, 6'h3F}
  };

  function automatic logic [COMP_W-1:0] sel_comp(input logic [ENTRY_W-1:0] entry,
                                                 input phase_e ph);
    case (ph)
      PH_R:    sel_comp = entry[3*COMP_W-1:2*COMP_W];
      PH_G:    sel_comp = entry[2*COMP_W-1:COMP_W];
      default: sel_comp = entry[COMP_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/cga_dac_palette.sv
// 16 x 18-bit colour register file, reset to the CGA palette, with one write
// port and two combinational read ports (pixel lookup and CPU read latch).
module cga_dac_palette
  import cga_dac_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]   i_pix_addr,
  output logic [ENTRY_W-1:0] o_pix_data,
  input  logic [IDX_W-1:0]   i_cpu_addr,
  output logic [ENTRY_W-1:0] o_cpu_data
);

  logic [ENTRY_W-1:0] r_mem [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_mem[i] <= DEFAULT_PALETTE[i];
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_pix_data = r_mem[i_pix_addr];
  assign o_cpu_data = r_mem[i_cpu_addr];

endmodule

// File: rtl/cga_dac_ctrl.sv
// Programmable CGA colour DAC: VGA-style index/data register sequencer on the
// CPU side, registered 4-bit-code to 18-bit RGB lookup on the pixel side.
module cga_dac_ctrl
  import cga_dac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_bus_addr,
  input  logic              i_bus_wr,
  input  logic              i_bus_rd,
  input  logic [7:0]        i_bus_wdata,
  output logic [7:0]        o_bus_rdata,
  input  logic [3:0]        i_video,
  input  logic              i_blank,
  output logic [COMP_W-1:0] o_red,
  output logic [COMP_W-1:0] o_green,
  output logic [COMP_W-1:0] o_blue
);

  logic [IDX_W-1:0]   r_widx, r_ridx, r_pel_mask;
  phase_e             r_wphase, r_rphase;
  logic [COMP_W-1:0]  r_stage_r, r_stage_g;
  logic [ENTRY_W-1:0] r_rlatch;
  logic [7:0]         r_rdata;
  logic [ENTRY_W-1:0] r_rgb;

  logic [IDX_W-1:0]   w_widx_nxt, w_ridx_nxt, w_pel_mask_nxt;
  phase_e             w_wphase_nxt, w_rphase_nxt;
  logic [COMP_W-1:0]  w_stage_r_nxt, w_stage_g_nxt;
  logic [ENTRY_W-1:0] w_rlatch_nxt;
  logic [7:0]         w_rdata_nxt;

  logic               w_rd;
  logic               w_commit;
  logic [ENTRY_W-1:0] w_commit_data;
  logic               w_reload;
  logic [IDX_W-1:0]   w_reload_idx;
  logic [IDX_W-1:0]   w_pix_idx;
  logic [ENTRY_W-1:0] w_pix_entry;
  logic [ENTRY_W-1:0] w_cpu_entry;
  logic               w_unused;

  assign w_unused = &{1'b0, i_bus_wdata[7:6]};

  // A write strobe always wins; a colliding read is simply dropped.
  assign w_rd          = i_bus_rd & ~i_bus_wr;
  assign w_commit      = i_bus_wr && (i_bus_addr == ADDR_DATA) && (r_wphase == PH_B);
  assign w_commit_data = {r_stage_r, r_stage_g, i_bus_wdata[COMP_W-1:0]};
  assign w_reload      = (i_bus_wr && (i_bus_addr == ADDR_RIDX)) ||
                         (w_rd && (i_bus_addr == ADDR_DATA) && (r_rphase == PH_B));
  assign w_reload_idx  = (i_bus_wr && (i_bus_addr == ADDR_RIDX)) ? i_bus_wdata[IDX_W-1:0]
                                                                  : r_ridx + 4'd1;
  assign w_pix_idx     = i_video & r_pel_mask;

  cga_dac_palette u_palette (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_commit),
    .i_waddr    (r_widx),
    .i_wdata    (w_commit_data),
    .i_pix_addr (w_pix_idx),
    .o_pix_data (w_pix_entry),
    .i_cpu_addr (w_reload_idx),
    .o_cpu_data (w_cpu_entry)
  );

  always_comb begin
    w_widx_nxt     = r_widx;
    w_wphase_nxt   = r_wphase;
    w_stage_r_nxt  = r_stage_r;
    w_stage_g_nxt  = r_stage_g;
    w_ridx_nxt     = r_ridx;
    w_rphase_nxt   = r_rphase;
    w_pel_mask_nxt = r_pel_mask;
    w_rdata_nxt    = r_rdata;
    w_rlatch_nxt   = r_rlatch;

    if (i_bus_wr) begin
      case (i_bus_addr)
        ADDR_WIDX: begin
          w_widx_nxt   = i_bus_wdata[IDX_W-1:0];
          w_wphase_nxt = PH_R;
        end
        ADDR_DATA: begin
          case (r_wphase)
            PH_R: begin
              w_stage_r_nxt = i_bus_wdata[COMP_W-1:0];
              w_wphase_nxt  = PH_G;
            end
            PH_G: begin
              w_stage_g_nxt = i_bus_wdata[COMP_W-1:0];
              w_wphase_nxt  = PH_B;
            end
            PH_B: begin
              w_widx_nxt   = r_widx + 4'd1;
              w_wphase_nxt = PH_R;
            end
            default: w_wphase_nxt = PH_R;
          endcase
        end
        ADDR_RIDX: begin
          w_ridx_nxt   = i_bus_wdata[IDX_W-1:0];
          w_rphase_nxt = PH_R;
        end
        default: w_pel_mask_nxt = i_bus_wdata[IDX_W-1:0];
      endcase
    end else if (w_rd) begin
      case (i_bus_addr)
        ADDR_WIDX: w_rdata_nxt = {4'h0, r_widx};
        ADDR_DATA: begin
          w_rdata_nxt = {2'b00, sel_comp(r_rlatch, r_rphase)};
          case (r_rphase)
            PH_R:    w_rphase_nxt = PH_G;
            PH_G:    w_rphase_nxt = PH_B;
            default: begin
              w_ridx_nxt   = r_ridx + 4'd1;
              w_rphase_nxt = PH_R;
            end
          endcase
        end
        ADDR_RIDX: w_rdata_nxt = {4'h0, r_ridx};
        default:   w_rdata_nxt = {r_rphase, r_wphase, r_pel_mask};
      endcase
    end

    // Forward a same-cycle commit so the latch never holds a stale entry.
    if (w_reload) begin
      w_rlatch_nxt = (w_commit && (w_reload_idx == r_widx)) ? w_commit_data : w_cpu_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx     <= '0;
      r_wphase   <= PH_R;
      r_stage_r  <= '0;
      r_stage_g  <= '0;
      r_ridx     <= '0;
      r_rphase   <= PH_R;
      r_pel_mask <= 4'hF;
      r_rdata    <= '0;
      r_rlatch   <= DEFAULT_PALETTE[0];
    end else begin
      r_widx     <= w_widx_nxt;
      r_wphase   <= w_wphase_nxt;
      r_stage_r  <= w_stage_r_nxt;
      r_stage_g  <= w_stage_g_nxt;
      r_ridx     <= w_ridx_nxt;
      r_rphase   <= w_rphase_nxt;
      r_pel_mask <= w_pel_mask_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rlatch   <= w_rlatch_nxt;
    end
  end

  // Pixel lookup sees the pre-commit palette, so a same-cycle update shows next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= i_blank ? '0 : w_pix_entry;
    end
  end

  assign o_bus_rdata = r_rdata;
  assign o_red       = r_rgb[3*COMP_W-1:2*COMP_W];
  assign o_green     = r_rgb[2*COMP_W-1:COMP_W];
  assign o_blue      = r_rgb[COMP_W-1:0];

endmodule

// File: tb/tb_cga_dac_ctrl.sv
// Directed self-checking bench for cga_dac_ctrl: default map, palette load and
// readback, index wrap, partial sequences, pel mask, blanking and async reset.
module tb_cga_dac_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] bus_addr;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic [3:0] video;
  logic       blank;
  logic [5:0] red, green, blue;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [17:0] expDefault [16] = '{
    {6'h00, 6'h00, 6'h00}, {6'h00, 6'h00, 6'h2A}, {6'h00, 6'h2A, 6'h00}, {6'h00, 6'h2A, 6'h2A},
    {6'h2A, 6'h00, 6'h00}, {6'h2A, 6'h00, 6'h2A}, {6'h2A, 6'h15, 6'h00}, {6'h2A, 6'h2A, 6'h2A},
    {6'h15, 6'h15, 6'h15}, {6'h15, 6'h15, 6'h3F}, {6'h15, 6'h3F, 6'h15}, {6'h15, 6'h3F, 6'h3F},
    {6'h3F, 6'h15, 6'h15}, {6'h3F, 6'h15, 6'h3F}, {6'h3F, 6'h3F, 6'h15}, {6'h3F, 6'h3F, 6'h3F}
  };

  cga_dac_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_bus_addr  (bus_addr),
    .i_bus_wr    (bus_wr),
    .i_bus_rd    (bus_rd),
    .i_bus_wdata (bus_wdata),
    .o_bus_rdata (bus_rdata),
    .i_video     (video),
    .i_blank     (blank),
    .o_red       (red),
    .o_green     (green),
    .o_blue      (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b0;
  endtask

  task automatic readCheck(input logic [1:0] addr, input logic [7:0] expected,
                           input string tag);
    @(negedge clk);
    bus_addr = addr;
    bus_rd   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(tag, {16'h0, bus_rdata}, {16'h0, expected});
    @(negedge clk);
    bus_rd = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic b);
    @(negedge clk);
    video = v;
    blank = b;
  endtask

  task automatic pixelCheck(input logic [3:0] v, input logic b, input logic [17:0] expected,
                            input string tag);
    applyStimulus(v, b);
    @(posedge clk);
    #1;
    checkOutput(tag, {6'h0, red, green, blue}, {6'h0, expected});
  endtask

  initial begin
    rst_n     = 1'b0;
    bus_addr  = 2'd0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = 8'h00;
    video     = 4'h7;
    blank     = 1'b0;
    #3;
    checkOutput("reset_rgb", {6'h0, red, green, blue}, 24'h0);
    checkOutput("reset_rdata", {16'h0, bus_rdata}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    readCheck(2'd3, 8'h0F, "reset_status");
    readCheck(2'd0, 8'h00, "reset_widx");

    for (int v = 0; v < 16; v++) begin
      pixelCheck(v[3:0], 1'b0, expDefault[v], $sformatf("sweep_%0d", v));
    end

    // Load entry 5 with magenta; the 0xFF byte checks that bits 7:6 are dropped.
    busWrite(2'd0, 8'h05);
    busWrite(2'd1, 8'hFF);
    busWrite(2'd1, 8'h00);
    busWrite(2'd1, 8'h3F);
    pixelCheck(4'h5, 1'b0, {6'h3F, 6'h00, 6'h3F}, "load5_pixel");
    readCheck(2'd0, 8'h06, "load5_widx");

    busWrite(2'd0, 8'hFF);
    busWrite(2'd1, 8'h01);
    busWrite(2'd1, 8'h02);
    busWrite(2'd1, 8'h03);
    busWrite(2'd1, 8'h04);
    busWrite(2'd1, 8'h05);
    busWrite(2'd1, 8'h06);
    pixelCheck(4'hF, 1'b0, {6'h01, 6'h02, 6'h03}, "wrap_entryF");
    pixelCheck(4'h0, 1'b0, {6'h04, 6'h05, 6'h06}, "wrap_entry0");
    readCheck(2'd0, 8'h01, "wrap_widx");

    busWrite(2'd0, 8'h02);
    busWrite(2'd1, 8'h10);
    busWrite(2'd1, 8'h11);
    pixelCheck(4'h2, 1'b0, {6'h00, 6'h2A, 6'h00}, "partial_entry2");
    readCheck(2'd3, 8'h2F, "partial_status");
    busWrite(2'd0, 8'h07);
    readCheck(2'd3, 8'h0F, "partial_wphase_clr");

    busWrite(2'd2, 8'h05);
    readCheck(2'd1, 8'h3F, "rd_r");
    readCheck(2'd1, 8'h00, "rd_g");
    readCheck(2'd1, 8'h3F, "rd_b");
    readCheck(2'd2, 8'h06, "rd_ridx");
    readCheck(2'd1, 8'h2A, "rd_next_r");
    repeat (3) @(negedge clk);
    checkOutput("rd_hold", {16'h0, bus_rdata}, 24'h00002A);

    // Simultaneous strobes: the widx write lands, the read never happens.
    @(negedge clk);
    bus_addr  = 2'd0;
    bus_wdata = 8'h09;
    bus_wr    = 1'b1;
    bus_rd    = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    checkOutput("collide_rdata", {16'h0, bus_rdata}, 24'h00002A);
    readCheck(2'd0, 8'h09, "collide_widx");

    busWrite(2'd3, 8'h03);
    pixelCheck(4'hF, 1'b0, {6'h00, 6'h2A, 6'h2A}, "mask_F_to_3");
    pixelCheck(4'hF, 1'b1, 18'h0, "blank");

    busWrite(2'd0, 8'h03);
    busWrite(2'd1, 8'h01);
    busWrite(2'd1, 8'h02);
    @(negedge clk);
    bus_addr  = 2'd1;
    bus_wdata = 8'h03;
    bus_wr    = 1'b1;
    video     = 4'h3;
    blank     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("commit_old", {6'h0, red, green, blue}, {6'h0, 6'h00, 6'h2A, 6'h2A});
    @(negedge clk);
    bus_wr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("commit_new", {6'h0, red, green, blue}, {6'h0, 6'h01, 6'h02, 6'h03});

    busWrite(2'd0, 8'h04);
    busWrite(2'd1, 8'h05);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rgb", {6'h0, red, green, blue}, 24'h0);
    checkOutput("async_rst_rdata", {16'h0, bus_rdata}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readCheck(2'd3, 8'h0F, "post_rst_status");
    pixelCheck(4'h3, 1'b0, expDefault[3], "post_rst_entry3");
    pixelCheck(4'h5, 1'b0, expDefault[5], "post_rst_entry5");
    pixelCheck(4'hF, 1'b0, expDefault[15], "post_rst_entryF");
    busWrite(2'd1, 8'h3F);
    busWrite(2'd1, 8'h3F);
    busWrite(2'd1, 8'h00);
    pixelCheck(4'h0, 1'b0, {6'h3F, 6'h3F, 6'h00}, "post_rst_load0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
